// File: rtl/spi_response_arbiter.sv
// Return-path scheduler for the SPI minion. It round-robin arbitrates the component
// response streams and registers {source index, data} toward the push-pull adapter.
module spi_response_arbiter #(
  parameter int nbits      = 4,
  parameter int num_inputs = 2,
  parameter int addr_nbits = (num_inputs > 1) ? $clog2(num_inputs) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [nbits-1:0]            recv_msg [num_inputs],
  input  logic [num_inputs-1:0]       recv_val,
  output logic [num_inputs-1:0]       recv_rdy,
  output logic [addr_nbits+nbits-1:0] send_msg,
  output logic                        send_val,
  input  logic                        send_rdy
);

  localparam int AW1 = addr_nbits + 1;
  localparam logic [addr_nbits:0] NUM_W = AW1'(num_inputs);

  logic                        out_full_r;
  logic [addr_nbits+nbits-1:0] data_r;
  logic [addr_nbits-1:0]       ptr_r;

  logic                  can_accept_s;
  logic                  found_s;
  logic                  accept_s;
  logic [num_inputs-1:0] win_s;
  logic [addr_nbits-1:0] win_idx_s;
  logic [nbits-1:0]      win_msg_s;
  logic [addr_nbits:0]   cand_s;
  logic [addr_nbits:0]   inc_s;
  logic [addr_nbits-1:0] ptr_nxt_s;

  // Round-robin scan starting at ptr, wrapping at num_inputs rather than at a power of two
  always_comb begin
    win_s     = {num_inputs{1'b0}};
    win_idx_s = {addr_nbits{1'b0}};
    win_msg_s = {nbits{1'b0}};
    found_s   = 1'b0;
    cand_s    = {AW1{1'b0}};
    for (int k = 0; k < num_inputs; k++) begin
      cand_s = {1'b0, ptr_r} + AW1'(k);
      if (cand_s >= NUM_W) begin
        cand_s = cand_s - NUM_W;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && recv_val[cand_s[addr_nbits-1:0]]) begin
        found_s   = 1'b1;
        win_idx_s = cand_s[addr_nbits-1:0];
        win_msg_s = recv_msg[cand_s[addr_nbits-1:0]];
        win_s[cand_s[addr_nbits-1:0]] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Handshake qualification and next pointer; a draining packet frees the slot this cycle
  always_comb begin
    can_accept_s = !out_full_r || send_rdy;
    accept_s     = found_s && can_accept_s;
    recv_rdy     = win_s & {num_inputs{can_accept_s}};
    inc_s        = {1'b0, win_idx_s} + AW1'(1);
    if (inc_s == NUM_W) begin
      ptr_nxt_s = {addr_nbits{1'b0}};
    end else begin
      ptr_nxt_s = inc_s[addr_nbits-1:0];
    end
  end

  // Output register, full flag and priority pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_full_r <= 1'b0;
      data_r     <= {(addr_nbits+nbits){1'b0}};
      ptr_r      <= {addr_nbits{1'b0}};
    end else if (accept_s) begin
      out_full_r <= 1'b1;
      data_r     <= {win_idx_s, win_msg_s};
      ptr_r      <= ptr_nxt_s;
    end else if (send_rdy) begin
      out_full_r <= 1'b0;
    end else begin
      out_full_r <= out_full_r;
    end
  end

  assign send_val = out_full_r;
  assign send_msg = data_r;

endmodule

// File: tb/tb_spi_response_arbiter.sv
// Directed bench for spi_response_arbiter: a 2-input instance and a 3-input
// instance (non-power-of-two wrap), checked against hand-computed vectors.
module tb_spi_response_arbiter;

  logic clk;
  logic reset;

  logic [3:0] msg2 [2];
  logic [1:0] val2;
  logic [1:0] rdy2;
  logic [4:0] smsg2;
  logic       sval2;
  logic       srdy2;

  logic [3:0] msg3 [3];
  logic [2:0] val3;
  logic [2:0] rdy3;
  logic [5:0] smsg3;
  logic       sval3;
  logic       srdy3;

  int pass_cnt;
  int total_cnt;

  spi_response_arbiter #(.nbits(4), .num_inputs(2)) dut2 (
    .clk(clk), .reset(reset),
    .recv_msg(msg2), .recv_val(val2), .recv_rdy(rdy2),
    .send_msg(smsg2), .send_val(sval2), .send_rdy(srdy2)
  );

  spi_response_arbiter #(.nbits(4), .num_inputs(3)) dut3 (
    .clk(clk), .reset(reset),
    .recv_msg(msg3), .recv_val(val3), .recv_rdy(rdy3),
    .send_msg(smsg3), .send_val(sval3), .send_rdy(srdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rr_msg [4];
  logic [1:0] rr_rdy [4];
  logic [5:0] wrap_msg [6];
  logic [2:0] wrap_val [6];

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b0;
    val2 = 2'b00; srdy2 = 1'b0;
    msg2[0] = 4'h0; msg2[1] = 4'h0;
    val3 = 3'b000; srdy3 = 1'b0;
    msg3[0] = 4'h1; msg3[1] = 4'h2; msg3[2] = 4'h3;

    rr_msg[0] = 5'h03; rr_msg[1] = 5'h15; rr_msg[2] = 5'h03; rr_msg[3] = 5'h15;
    rr_rdy[0] = 2'b01; rr_rdy[1] = 2'b10; rr_rdy[2] = 2'b01; rr_rdy[3] = 2'b10;
    wrap_val[0] = 3'b111; wrap_val[1] = 3'b111; wrap_val[2] = 3'b111; wrap_val[3] = 3'b111;
    wrap_val[4] = 3'b101; wrap_val[5] = 3'b101;
    wrap_msg[0] = 6'h01; wrap_msg[1] = 6'h12; wrap_msg[2] = 6'h23; wrap_msg[3] = 6'h01;
    wrap_msg[4] = 6'h23; wrap_msg[5] = 6'h01;

    // Reset held for two cycles, then idle
    tick();
    tick();
    check_eq("rst_sval", 32'(sval2), 32'd0);
    check_eq("rst_smsg", 32'(smsg2), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_sval", 32'(sval2), 32'd0);
      check_eq("idle_smsg", 32'(smsg2), 32'd0);
      check_eq("idle_rdy", 32'(rdy2), 32'd0);
    end
    check_eq("idle_sval3", 32'(sval3), 32'd0);

    // Single source on input 1
    srdy2 = 1'b1;
    val2 = 2'b10; msg2[1] = 4'hA;
    #1;
    check_eq("single_rdy", 32'(rdy2), 32'h2);
    tick();
    val2 = 2'b00;
    check_eq("single_sval", 32'(sval2), 32'd1);
    check_eq("single_smsg", 32'(smsg2), 32'h1A);
    tick();
    check_eq("drain_sval", 32'(sval2), 32'd0);

    // Round robin between inputs 0 and 1, one packet per cycle
    val2 = 2'b11; msg2[0] = 4'h3; msg2[1] = 4'h5;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_rdy", 32'(rdy2), 32'(rr_rdy[i]));
      tick();
      check_eq("rr_sval", 32'(sval2), 32'd1);
      check_eq("rr_smsg", 32'(smsg2), 32'(rr_msg[i]));
    end

    // Backpressure: held packet stays stable, nothing granted
    srdy2 = 1'b0;
    #1;
    check_eq("bp_rdy0", 32'(rdy2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_sval", 32'(sval2), 32'd1);
      check_eq("bp_smsg", 32'(smsg2), 32'h15);
      check_eq("bp_rdy", 32'(rdy2), 32'd0);
    end
    srdy2 = 1'b1;
    #1;
    check_eq("bp_pipe_rdy", 32'(rdy2), 32'h1);
    tick();
    check_eq("bp_pipe_sval", 32'(sval2), 32'd1);
    check_eq("bp_pipe_smsg", 32'(smsg2), 32'h03);
    val2 = 2'b00;
    tick();
    check_eq("bp_drain_sval", 32'(sval2), 32'd0);

    // Three inputs: wrap at 3, then ptr=1 with inputs 0 and 2 valid
    srdy3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      val3 = wrap_val[i];
      tick();
      check_eq("wrap_sval", 32'(sval3), 32'd1);
      check_eq("wrap_smsg", 32'(smsg3), 32'(wrap_msg[i]));
      check_eq("wrap_idx_lt3", 32'(smsg3[5:4] != 2'b11), 32'd1);
    end
    val3 = 3'b000;
    tick();
    check_eq("wrap_drain", 32'(sval3), 32'd0);

    // Move dut2 ptr to 1 and hold a packet, then reset asynchronously
    val2 = 2'b01; msg2[0] = 4'h3;
    #1;
    check_eq("ar_rdy", 32'(rdy2), 32'h1);
    tick();
    val2 = 2'b00; srdy2 = 1'b0;
    check_eq("ar_sval_pre", 32'(sval2), 32'd1);
    check_eq("ar_smsg_pre", 32'(smsg2), 32'h03);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_sval", 32'(sval2), 32'd0);
    check_eq("ar_smsg", 32'(smsg2), 32'd0);
    tick();
    reset = 1'b1;
    val2 = 2'b11; srdy2 = 1'b1; msg2[0] = 4'h3; msg2[1] = 4'h5;
    #1;
    check_eq("ar_first_rdy", 32'(rdy2), 32'h1);
    tick();
    check_eq("ar_first_smsg", 32'(smsg2), 32'h03);
    val2 = 2'b00;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_response_arbiter.md
Name: spi_response_arbiter

Overview:
- Return-path scheduler for the SPI minion: shares the single upstream channel into the push-pull adapter among `num_inputs` component response streams.
- It is the mirror of the address router. The router strips address bits and fans out; this block round-robin arbitrates, prepends the winning source index as address bits, and registers the result.
- The adapter can then tell the SPI master which component produced each packet.

Parameters:
- nbits, 4, data width of each component response.
- num_inputs, 2, number of responding components (≥1, need not be a power of 2).
- addr_nbits, max(1, clog2(num_inputs)), width of the source index prepended to send_msg.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- recv_msg  input  nbits x [0:num_inputs-1]  per-component response data.
- recv_val  input  1 x [0:num_inputs-1]  per-component valid.
- recv_rdy  output  1 x [0:num_inputs-1]  per-component ready; at most one high per cycle.
- send_msg  output  addr_nbits+nbits  {source index, data} toward the adapter.
- send_val  output  1  output register holds a packet.
- send_rdy  input  1  adapter can accept.

Behaviour:
- Reset (reset==0, asynchronous):
  - out_full=0, so send_val=0.
  - send_msg register = 0.
  - priority pointer ptr = 0.
  - Reset mid-transfer discards the held packet; no input is accepted that cycle.
- State:
  - out_full flag.
  - Output data register, addr_nbits+nbits wide.
  - ptr, range 0..num_inputs-1.
- can_accept = !out_full | send_rdy (pipe-through when the held packet drains in the same cycle).
- Grant (combinational):
  - Scan indices ptr, ptr+1, ... with wrap at num_inputs (not at 2^addr_nbits).
  - The first i with recv_val[i]==1 wins.
  - recv_rdy[i] = win[i] & can_accept. recv_rdy depends combinationally on recv_val and send_rdy, as in the rest of the SPI components.
- Accept: recv_val[i] & recv_rdy[i].
  - Next cycle: register = {i[addr_nbits-1:0], recv_msg[i]}, out_full=1.
  - ptr = (i+1 == num_inputs) ? 0 : i+1.
- Drain only (send_val & send_rdy, no accept): out_full=0 next cycle. The register keeps its old value, which is don't-care while send_val==0.
- Drain and accept in the same cycle: out_full stays 1 and the register is replaced. Throughput is one packet per cycle.
- Latency: exactly one cycle from the accept edge to send_val=1. No combinational path from recv_msg to send_msg.
- No valid inputs: ptr unchanged, all recv_rdy=0.
- out_full & !send_rdy: all recv_rdy=0. send_msg and send_val are held stable until the handshake.
- num_inputs==1: index field is 1 bit, always 0; ptr stays 0.
- Fairness: a continuously valid input waits at most num_inputs-1 grants to other inputs.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, all recv_val=0 → send_val=0, send_msg=0, all recv_rdy=0 for 5 cycles.
- Single source: nbits=4, num_inputs=2; recv_val[1]=1, recv_msg[1]=4'hA, send_rdy=1 → recv_rdy[1]=1 that cycle; next cycle send_val=1, send_msg=5'b1_1010.
- Round-robin: inputs 0 and 1 valid continuously with msgs 3 and 5, send_rdy=1 → send_msg sequence 5'h03, 5'h15, 5'h03, 5'h15, one per cycle.
- Backpressure: packet held, send_rdy=0 for 4 cycles → send_val=1 and send_msg stable, recv_rdy all 0. When send_rdy=1 again, held packet drains and a new input is accepted in the same cycle.
- Non-power-of-2 wrap: num_inputs=3, all valid → grant order 0,1,2,0; index 3 never appears in send_msg.
- Async reset mid-operation: assert reset=0 between clock edges while send_val=1 → send_val drops to 0 immediately. After release, first grant goes to input 0 (ptr=0).
